// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: tracks EX/MEM/WB destinations and raises a zero-latency stall.
// Optional build macro FULL_INTERLOCK_EN: no-forwarding interlock on any EX or MEM producer.
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_valid,
    input  logic        id_rt_valid,
    input  logic [2:0]  id_rd,
    input  logic        id_rd_valid,
    input  logic        id_is_load,
    input  logic        flush,
    input  logic        hold,
    output logic        stall,
    output logic [7:0]  busy_rd,
    output logic        drained,
    output logic [15:0] stall_cnt
);

    typedef struct packed {
        logic       v;
        logic [2:0] rd;
        logic       ld;
    } slot_t;

    slot_t       ex_q, mem_q, wb_q;
    slot_t       ex_d, mem_d, wb_d;
    slot_t       issue;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        hit_rs, hit_rt;

`ifdef FULL_INTERLOCK_EN
    assign hit_rs = (ex_q.v && (ex_q.rd == id_rs)) || (mem_q.v && (mem_q.rd == id_rs));
    assign hit_rt = (ex_q.v && (ex_q.rd == id_rt)) || (mem_q.v && (mem_q.rd == id_rt));
`else
    // Only a load in EX is unforwardable; register 0 is tracked like any other.
    assign hit_rs = ex_q.v && ex_q.ld && (ex_q.rd == id_rs);
    assign hit_rt = ex_q.v && ex_q.ld && (ex_q.rd == id_rt);
`endif

    // Flush wins over stall: a squashed instruction never waits on a producer.
    assign stall = id_valid && !flush &&
                   ((id_rs_valid && hit_rs) || (id_rt_valid && hit_rt));

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        issue       = '0;
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        if (id_valid && id_rd_valid && !stall && !flush) begin
            issue.v  = 1'b1;
            issue.rd = id_rd;
            issue.ld = id_is_load;
        end
        if (!hold) begin
            ex_d  = issue;
            mem_d = ex_q;
            wb_d  = mem_q;
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        busy_rd = '0;
        for (int i = 0; i < 8; i++) begin
            busy_rd[i] = (ex_q.v && (ex_q.rd == 3'(i))) || (mem_q.v && (mem_q.rd == 3'(i)));
        end
    end

    assign drained   = !ex_q.v && !mem_q.v && !wb_q.v;
    assign stall_cnt = stall_cnt_q;

    // NOTE: state uses non-blocking assignments so all slots advance from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard; expectations follow the build selected by FULL_INTERLOCK_EN.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_rs_valid, id_rt_valid, id_rd_valid, id_is_load;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic        flush, hold;
    logic        stall, drained;
    logic [7:0]  busy_rd;
    logic [15:0] stall_cnt;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid),
        .id_rd(id_rd), .id_rd_valid(id_rd_valid), .id_is_load(id_is_load),
        .flush(flush), .hold(hold),
        .stall(stall), .busy_rd(busy_rd), .drained(drained), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [2:0]  rs;
        logic        rsv;
        logic [2:0]  rt;
        logic        rtv;
        logic [2:0]  rd;
        logic        rdv;
        logic        ld;
        logic        fl;
        logic        hd;
        logic        e_stall;
        logic [7:0]  e_busy;
        logic        e_dr;
        logic [15:0] e_cnt;
        string       tag;
    } vec_t;

    typedef struct {
        logic        stall;
        logic [7:0]  busy;
        logic        dr;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

`ifdef FULL_INTERLOCK_EN
    localparam int K_A = 2, K_B = 4, K_C = 6, K_F = 8;
`else
    localparam int K_A = 1, K_B = 1, K_C = 2, K_F = 3;
`endif

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t ins(int rs, bit rsv, int rt, bit rtv, int rd, bit rdv, bit ld,
                                 bit fl, bit hd, bit s, logic [7:0] busy, bit dr, int cnt,
                                 string tag);
        vec_t v;
        v.iv = 1'b1; v.rs = 3'(rs); v.rsv = rsv; v.rt = 3'(rt); v.rtv = rtv;
        v.rd = 3'(rd); v.rdv = rdv; v.ld = ld; v.fl = fl; v.hd = hd;
        v.e_stall = s; v.e_busy = busy; v.e_dr = dr; v.e_cnt = 16'(cnt); v.tag = tag;
        return v;
    endfunction

    function automatic vec_t idle(logic [7:0] busy, bit dr, int cnt, string tag);
        vec_t v;
        v = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, busy, dr, cnt, tag);
        v.iv = 1'b0;
        return v;
    endfunction

    function automatic int sat(int x);
        return (x > 16'hFFFF) ? 16'hFFFF : x;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.iv; id_rs = v.rs; id_rs_valid = v.rsv; id_rt = v.rt; id_rt_valid = v.rtv;
        id_rd = v.rd; id_rd_valid = v.rdv; id_is_load = v.ld; flush = v.fl; hold = v.hd;
    endtask

    task automatic expect_out(input bit s, input logic [7:0] busy, input bit dr,
                              input logic [15:0] cnt, input string tag);
        exp_t e;
        e.stall = s; e.busy = busy; e.dr = dr; e.cnt = cnt; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        if (stall !== e.stall || busy_rd !== e.busy || drained !== e.dr || stall_cnt !== e.cnt) begin
            n_miss++;
            $display("FAIL %s: got stall=%b busy_rd=%h drained=%b stall_cnt=%h, want stall=%b busy_rd=%h drained=%b stall_cnt=%h",
                     e.tag, stall, busy_rd, drained, stall_cnt, e.stall, e.busy, e.dr, e.cnt);
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        expect_out(v.e_stall, v.e_busy, v.e_dr, v.e_cnt, v.tag);
        @(negedge clk);
        check_out();
    endtask

    task automatic fill_tbl();
        // Load-use on r3
        tbl.push_back(ins(0,0,0,0,3,1,1, 0,0, 0,8'h00,1,0, "lu_issue"));
`ifdef FULL_INTERLOCK_EN
        tbl.push_back(ins(3,1,0,0,4,1,0, 0,0, 1,8'h08,0,0, "lu_stall1"));
        tbl.push_back(ins(3,1,0,0,4,1,0, 0,0, 1,8'h08,0,1, "lu_stall2"));
        tbl.push_back(ins(3,1,0,0,4,1,0, 0,0, 0,8'h00,0,2, "lu_go"));
`else
        tbl.push_back(ins(3,1,0,0,4,1,0, 0,0, 1,8'h08,0,0, "lu_stall"));
        tbl.push_back(ins(3,1,0,0,4,1,0, 0,0, 0,8'h08,0,1, "lu_go"));
`endif
        tbl.push_back(idle(8'h10,0,K_A, "lu_cons_ex"));
        tbl.push_back(idle(8'h10,0,K_A, "lu_cons_mem"));
        tbl.push_back(idle(8'h00,0,K_A, "lu_cons_wb"));
        tbl.push_back(idle(8'h00,1,K_A, "lu_drained"));
        // ALU producer r5, consumer on rt
        tbl.push_back(ins(0,0,0,0,5,1,0, 0,0, 0,8'h00,1,K_A, "alu_issue"));
`ifdef FULL_INTERLOCK_EN
        tbl.push_back(ins(0,0,5,1,6,1,0, 0,0, 1,8'h20,0,K_A,   "alu_stall1"));
        tbl.push_back(ins(0,0,5,1,6,1,0, 0,0, 1,8'h20,0,K_A+1, "alu_stall2"));
        tbl.push_back(ins(0,0,5,1,6,1,0, 0,0, 0,8'h00,0,K_A+2, "alu_go"));
        tbl.push_back(idle(8'h40,0,K_B, "alu_cons_ex"));
`else
        tbl.push_back(ins(0,0,5,1,6,1,0, 0,0, 0,8'h20,0,K_A, "alu_no_stall"));
        tbl.push_back(idle(8'h60,0,K_B, "alu_both"));
`endif
        tbl.push_back(idle(8'h40,0,K_B, "alu_cons_mem"));
        tbl.push_back(idle(8'h00,0,K_B, "alu_cons_wb"));
        tbl.push_back(idle(8'h00,1,K_B, "alu_drained"));
        // Load into r0, consumer reads r0 on both sources
        tbl.push_back(ins(0,0,0,0,0,1,1, 0,0, 0,8'h00,1,K_B, "r0_issue"));
`ifdef FULL_INTERLOCK_EN
        tbl.push_back(ins(0,1,0,1,7,1,0, 0,0, 1,8'h01,0,K_B,   "dual_stall1"));
        tbl.push_back(ins(0,1,0,1,7,1,0, 0,0, 1,8'h01,0,K_B+1, "dual_stall2"));
        tbl.push_back(ins(0,1,0,1,7,1,0, 0,0, 0,8'h00,0,K_B+2, "dual_go"));
`else
        tbl.push_back(ins(0,1,0,1,7,1,0, 0,0, 1,8'h01,0,K_B,   "dual_stall"));
        tbl.push_back(ins(0,1,0,1,7,1,0, 0,0, 0,8'h01,0,K_B+1, "dual_go"));
`endif
        tbl.push_back(idle(8'h80,0,K_C, "dual_cons_ex"));
        tbl.push_back(idle(8'h80,0,K_C, "dual_cons_mem"));
        tbl.push_back(idle(8'h00,0,K_C, "dual_cons_wb"));
        tbl.push_back(idle(8'h00,1,K_C, "dual_drained"));
        // Source-valid gating: matching rs that is not read
        tbl.push_back(ins(0,0,0,0,2,1,1, 0,0, 0,8'h00,1,K_C, "gate_issue"));
        tbl.push_back(ins(2,0,1,1,0,0,0, 0,0, 0,8'h04,0,K_C, "gate_rs_unread"));
        tbl.push_back(idle(8'h04,0,K_C, "gate_mem"));
        tbl.push_back(idle(8'h00,0,K_C, "gate_wb"));
        tbl.push_back(idle(8'h00,1,K_C, "gate_drained"));
        // Flush collides with load-use on r2
        tbl.push_back(ins(0,0,0,0,2,1,1, 0,0, 0,8'h00,1,K_C, "fl_issue"));
        tbl.push_back(ins(2,1,0,0,3,1,0, 1,0, 0,8'h04,0,K_C, "fl_no_stall"));
        tbl.push_back(idle(8'h04,0,K_C, "fl_bubble"));
        tbl.push_back(idle(8'h00,0,K_C, "fl_busy_clear"));
        tbl.push_back(idle(8'h00,1,K_C, "fl_drained"));
        // Hold for three cycles during a load-use stall
        tbl.push_back(ins(0,0,0,0,3,1,1, 0,0, 0,8'h00,1,K_C, "hold_issue"));
        tbl.push_back(ins(3,1,0,0,4,1,0, 0,1, 1,8'h08,0,K_C, "hold_1"));
        tbl.push_back(ins(3,1,0,0,4,1,0, 0,1, 1,8'h08,0,K_C, "hold_2"));
        tbl.push_back(ins(3,1,0,0,4,1,0, 0,1, 1,8'h08,0,K_C, "hold_3"));
        tbl.push_back(ins(3,1,0,0,4,1,0, 0,0, 1,8'h08,0,K_C, "hold_release"));
`ifdef FULL_INTERLOCK_EN
        tbl.push_back(ins(3,1,0,0,4,1,0, 0,0, 1,8'h08,0,K_C+1, "hold_stall2"));
        tbl.push_back(ins(3,1,0,0,4,1,0, 0,0, 0,8'h00,0,K_C+2, "hold_go"));
`else
        tbl.push_back(ins(3,1,0,0,4,1,0, 0,0, 0,8'h08,0,K_C+1, "hold_go"));
`endif
        tbl.push_back(idle(8'h10,0,K_F, "hold_cons_ex"));
        tbl.push_back(idle(8'h10,0,K_F, "hold_cons_mem"));
        tbl.push_back(idle(8'h00,0,K_F, "hold_cons_wb"));
        tbl.push_back(idle(8'h00,1,K_F, "hold_drained"));
    endtask

    initial begin
        vec_t cons;
        rst_n = 1'b0;
        drive(idle(8'h00, 1, 0, "init"));

        #3;
        expect_out(0, 8'h00, 1, 16'h0000, "reset_async");
        check_out();
        #4;
        expect_out(0, 8'h00, 1, 16'h0000, "reset_after_edge");
        check_out();
        #5;
        rst_n = 1'b1;

        fill_tbl();
        foreach (tbl[i]) apply(tbl[i]);

        // Jump the counter close to the top so saturation is reached in a few stalls.
        force dut.stall_cnt_q = 16'hFFFB;
        #1;
        release dut.stall_cnt_q;
        for (int k = 0; k < 6; k++) begin
            apply(ins(0,0,0,0,3,1,1, 0,0, 0, (k == 0) ? 8'h00 : 8'h08, (k == 0),
                      sat(16'hFFFB + k), "sat_issue"));
            apply(ins(3,1,0,0,0,0,0, 0,0, 1, 8'h08, 0, sat(16'hFFFB + k), "sat_stall"));
        end
        apply(ins(0,0,0,0,3,1,1, 0,0, 0,8'h08,0,16'hFFFF, "sat_hold_top"));

        // Asynchronous reset pulse while a stall is asserted
        cons = ins(3,1,0,0,0,0,0, 0,0, 1,8'h08,0,16'hFFFF, "rst_pre_stall");
        apply(cons);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out(0, 8'h00, 1, 16'h0000, "rst_mid_stall");
        check_out();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        expect_out(0, 8'h00, 1, 16'h0000, "rst_after");
        check_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Ports (name  direction  width  meaning) SHALL be exactly:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  instruction valid in decode.
- id_rs, id_rt  in  3 each  decode source register numbers.
- id_rs_valid, id_rt_valid  in  1 each  source actually read.
- id_rd  in  3  decode destination register.
- id_rd_valid  in  1  decode instruction writes a register.
- id_is_load  in  1  decode instruction is a load.
- flush  in  1  squash the decode instruction (branch taken in EX).
- hold  in  1  global pipeline freeze (memory busy).
- stall  out  1  hold IF/ID and inject a bubble into ID/EX.
- busy_rd  out  8  per-register pending-write mask.
- drained  out  1  no tracked instruction in flight.
- stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-003 The block SHALL keep three tracking slots, EX, MEM and WB, each holding {v, rd[2:0], ld}.
REQ-004 Slot advance SHALL occur on every edge with hold=0: WB<=MEM, MEM<=EX, EX<=issue entry.
REQ-005 The issue entry SHALL be {1, id_rd, id_is_load} when id_valid & id_rd_valid & !stall & !flush; otherwise a bubble with v=0.
REQ-006 With hold=1, all slots and stall_cnt SHALL hold their values; stall SHALL still be computed.
REQ-007 hit(r) (default build) SHALL be EX.v & EX.ld & (EX.rd==r); register 0 is an ordinary register and SHALL NOT be excluded.
REQ-008 stall SHALL be combinational, with no latency: id_valid & !flush & ((id_rs_valid & hit(id_rs)) | (id_rt_valid & hit(id_rt))).
REQ-009 A load-use dependency SHALL therefore stall for exactly 1 cycle; on the next cycle the load is in MEM and forwarding covers it.
REQ-010 The WB slot SHALL never cause a stall, because the register file writes before it reads.
REQ-011 busy_rd[i] SHALL be 1 iff a valid EX or MEM slot has rd==i.
REQ-012 drained SHALL be 1 iff EX.v, MEM.v and WB.v are all 0.
REQ-013 stall_cnt SHALL increment by 1 on each edge with stall=1 & hold=0, and SHALL saturate at 16'hFFFF without wrapping.
REQ-014 flush and stall together SHALL behave as flush: stall=0 and a bubble is issued.
REQ-015 When id_rs==id_rt and both match, the stall SHALL last 1 cycle and SHALL count once per cycle.

Reset
REQ-016 rst_n=0 SHALL immediately clear all slot v bits and stall_cnt, independent of clk.
REQ-017 During and directly after reset, outputs SHALL be: stall=0, busy_rd=8'h00, drained=1, stall_cnt=0.
REQ-018 Reset asserted mid-stall SHALL drop stall within the same cycle; no partial state SHALL survive.

Configuration
REQ-019 Macro FULL_INTERLOCK_EN, when defined, SHALL set hit(r) = (EX.v & EX.rd==r) | (MEM.v & MEM.rd==r), ignoring ld.
- This is the no-forwarding build: an ALU producer stalls a dependent consumer for 2 cycles, a gap-1 dependency for 1 cycle.
REQ-020 Without FULL_INTERLOCK_EN, hit SHALL follow REQ-007.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Load-use: issue LD r3; next cycle id_rs=3 valid -> stall=1 for 1 cycle, stall_cnt=1; the consumer issues on the following cycle.
- ALU-use, default build: ADD r5 then consumer of r5 -> stall=0 throughout. With FULL_INTERLOCK_EN: stall=1 for 2 cycles, stall_cnt=2.
- Hold during load-use: hold=1 for 3 cycles while stall=1 -> stall stays 1, stall_cnt unchanged; after hold drops, 1 counted stall cycle.
- Flush collision: LD r2 in EX, decode reads r2, flush=1 -> stall=0; the EX slot next cycle is a bubble; busy_rd[2] clears after 2 advances.
- Drain: issue LD r1 then bubbles -> busy_rd=8'h02 for 2 cycles, then drained=1 on the 3rd edge after issue.
- Saturation and reset: force 65540 stall cycles -> stall_cnt=16'hFFFF; pulse rst_n low mid-cycle -> stall_cnt=0 and drained=1 immediately.
